mul_rr_sched: RTL and testbench
===============================

# mul_rr_sched

Round-robin scheduler that shares one repeated-addition multiplier datapath among `N_REQ` requesters. It arbitrates pending requests and steers the winner's operands onto the datapath load bus. It then sequences the datapath control strobes (`loada`, `loadb`, `clrP`, `loadP`, `decb`) until the datapath reports `eqz`, and returns the product to the winning requester. It sits between client blocks and the multiplier datapath and replaces direct per-client control FSMs.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 16, operand width; the product is `2*WIDTH` bits
- `clk`  in  1  rising-edge clock, the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester request level
- `a_in`  in  N_REQ*WIDTH  packed multiplicand; slice i belongs to requester i
- `b_in`  in  N_REQ*WIDTH  packed multiplier; slice i belongs to requester i
- `gnt`  out  N_REQ  one-hot grant, held from LOADA through DONE
- `busy`  out  1  high whenever the state is not IDLE
- `dp_data`  out  WIDTH  operand bus to the datapath
- `loada`, `loadb`, `clrP`, `loadP`, `decb`  out  1 each  datapath strobes
- `eqz`  in  1  datapath B-register-is-zero flag
- `dp_prod`  in  2*WIDTH  datapath P register
- `rsp_valid`  out  N_REQ  one-cycle one-hot completion pulse
- `rsp_prod`  out  2*WIDTH  captured product, held until the next DONE
- `rsp_err`  out  1  watchdog abort flag, qualified by `rsp_valid`

## Operation
- **FSM states:** IDLE, LOADA, LOADB, MUL, DONE.
- **IDLE:** if `req` is nonzero, pick the winner by round-robin, register `gnt` and the winner index, then go to LOADA. Otherwise stay in IDLE.
- **Round-robin:** search starts at `last+1` modulo `N_REQ`. `last` updates to the winner at grant time. Reset value of `last` is `N_REQ-1`, so requester 0 has highest priority first.
- **LOADA:** `loada`=1, `dp_data`=a slice of the winner. Next state is LOADB.
- **LOADB:** `loadb`=1, `clrP`=1, `dp_data`=b slice of the winner. Clear the iteration counter. Next state is MUL.
- **MUL:**
  - `loadP` = `decb` = ~`eqz`, `dp_data`=a slice of the winner.
  - When `eqz`=0, the iteration counter increments.
  - Go to DONE when `eqz`=1, or when the counter reaches 2^WIDTH−1 with `eqz` still 0 (watchdog).
  - B=0 therefore produces zero additions and product 0.
- **DONE:**
  - Capture `dp_prod` into `rsp_prod`.
  - Pulse `rsp_valid[winner]`.
  - `rsp_err`=1 only if the exit from MUL was the watchdog.
  - Clear `gnt`; next state is IDLE.
- **Request handshake:**
  - A requester holds `req` and its operands stable until it sees its own `rsp_valid`, then drops `req` or presents a new job.
  - A granted job always runs to completion, even if `req` falls mid-job; the response pulse is still issued.
  - Operands are sampled live from the winner's slice, not latched. Changing them during LOADA/LOADB gives undefined results.
- **Outputs in other states:** all datapath strobes are 0 in IDLE and DONE. `dp_data` is 0 in IDLE.
- **Arithmetic:** the iteration counter is WIDTH bits and saturates at the watchdog limit. The product is passed through unchanged.

## Timing
- **Reset values:** `rst_n` low clears asynchronously: state=IDLE, `gnt`=0, `busy`=0, all strobes=0, `dp_data`=0, `rsp_valid`=0, `rsp_prod`=0, `rsp_err`=0, `last`=N_REQ−1, counter=0.
- **Reset mid-job:** the job is dropped with no response. The datapath contents are not this block's concern.
- **Outputs:** strobes, `dp_data`, and `busy` decode from the registered state (Moore). The only exception is `loadP`/`decb` in MUL, which are gated combinationally by `eqz`.
- **Latency:**
  - Request seen in IDLE at edge 0.
  - LOADA in cycle 1, LOADB in cycle 2.
  - MUL occupies cycles 3..3+B; the last MUL cycle has `eqz`=1.
  - DONE, with `rsp_valid` high, is cycle 4+B.
  - Total request-to-response is B+4 cycles.
- **Back-to-back:** a pending request is granted at the first IDLE cycle, so the minimum gap between successive jobs is one IDLE cycle.
- **Simultaneous events:** a new `req` arriving during a job waits. If several requests are pending at the IDLE evaluation, exactly one is granted, chosen by round-robin.

## Test plan
- **Single request:** requester 0 with a=3, b=4. Expect `gnt`=0001 from cycle 1 to cycle 8, four `loadP` pulses, `rsp_valid`=0001 in cycle 8, `rsp_prod`=12, `rsp_err`=0.
- **Zero multiplier:** requester 2 with a=7, b=0. Expect no `loadP` pulses, `rsp_prod`=0, `rsp_valid`=0100 in cycle 4.
- **Contention:** all four requesters hold `req` with b=1. Grant order is 0,1,2,3,0, and each response comes 5 cycles after its grant's IDLE evaluation.
- **Reset mid-MUL:** `rst_n` asserted during job a=5, b=10. All outputs go to 0 immediately, no `rsp_valid` pulse, and requester 0 wins next.
- **Watchdog:** WIDTH=4 with `eqz` forced low. `rsp_valid` fires with `rsp_err`=1 after 15 MUL iterations.
- **Dropped request:** requester 1 deasserts `req` in LOADB (a=2, b=3). The job still completes with `rsp_prod`=6 and `rsp_valid`=0010.

Source files
------------

// File: rtl/mul_rr_sched_if.sv
// Bundle of client-side and datapath-side signals of the shared multiplier scheduler.
// slave is the scheduler's view; master is the view of whatever drives requests and the datapath.
interface mul_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [WIDTH-1:0]       dp_data;
    logic                   loada;
    logic                   loadb;
    logic                   clrP;
    logic                   loadP;
    logic                   decb;
    logic                   eqz;
    logic [2*WIDTH-1:0]     dp_prod;
    logic [N_REQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]     rsp_prod;
    logic                   rsp_err;

    modport slave (
        input  req, a_in, b_in, eqz, dp_prod,
        output gnt, busy, dp_data, loada, loadb, clrP, loadP, decb,
               rsp_valid, rsp_prod, rsp_err
    );

    modport master (
        output req, a_in, b_in, eqz, dp_prod,
        input  gnt, busy, dp_data, loada, loadb, clrP, loadP, decb,
               rsp_valid, rsp_prod, rsp_err
    );
endinterface

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath among N_REQ clients.
// Sequences loada/loadb/clrP/loadP/decb until eqz, then returns the product to the winner.
module mul_rr_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_rr_sched_if.slave    bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOADA = 3'd1;
    localparam logic [2:0] S_LOADB = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [2:0]         r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_win;
    logic [IDX_W-1:0]   r_last;
    logic [WIDTH-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [2*WIDTH-1:0] r_rsp_prod;
    logic               r_rsp_err;

    logic [IDX_W-1:0]   w_pick;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_dp_data;
    logic               w_loada;
    logic               w_loadb;
    logic               w_clrp;
    logic               w_loadp;
    logic               w_decb;
    logic               w_mul_exit;

    // First pending requester found scanning upward from last+1, wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    assign w_pick     = rr_pick(bus.req, r_last);
    assign w_a        = bus.a_in[int'(r_win)*WIDTH +: WIDTH];
    assign w_b        = bus.b_in[int'(r_win)*WIDTH +: WIDTH];
    assign w_mul_exit = bus.eqz || (r_cnt == CNT_MAX);

    // Moore decode of the strobes; loadP/decb alone are gated live by eqz.
    always_comb begin
        w_dp_data = '0;
        w_loada   = 1'b0;
        w_loadb   = 1'b0;
        w_clrp    = 1'b0;
        w_loadp   = 1'b0;
        w_decb    = 1'b0;
        case (r_state)
            S_LOADA: begin
                w_loada   = 1'b1;
                w_dp_data = w_a;
            end
            S_LOADB: begin
                w_loadb   = 1'b1;
                w_clrp    = 1'b1;
                w_dp_data = w_b;
            end
            S_MUL: begin
                w_loadp   = ~bus.eqz;
                w_decb    = ~bus.eqz;
                w_dp_data = w_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_win       <= '0;
            r_last      <= IDX_W'(N_REQ - 1);
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_prod  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req) begin
                        r_win   <= w_pick;
                        r_last  <= w_pick;
                        r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_state <= S_LOADA;
                    end
                end
                S_LOADA: r_state <= S_LOADB;
                S_LOADB: begin
                    r_cnt   <= '0;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    // The product is stable here (loadP is off on the eqz cycle), so capture
                    // it on the way out and raise the response for the whole DONE cycle.
                    if (w_mul_exit) begin
                        r_rsp_prod  <= bus.dp_prod;
                        r_rsp_err   <= ~bus.eqz;
                        r_rsp_valid <= r_gnt;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dp_data   = w_dp_data;
    assign bus.loada     = w_loada;
    assign bus.loadb     = w_loadb;
    assign bus.clrP      = w_clrp;
    assign bus.loadP     = w_loadp;
    assign bus.decb      = w_decb;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_prod  = r_rsp_prod;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_mul_rr_sched.sv
// Scoreboard bench for mul_rr_sched: a behavioural repeated-addition datapath serves the
// main instance; a narrow second instance with eqz held low exercises the watchdog exit.
module tb_mul_rr_sched;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mul_rr_sched_if #(.N_REQ(4), .WIDTH(16)) bus ();
    mul_rr_sched_if #(.N_REQ(2), .WIDTH(4))  wbus ();

    mul_rr_sched #(.N_REQ(4), .WIDTH(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mul_rr_sched #(.N_REQ(2), .WIDTH(4)) u_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    // Behavioural datapath: A, B, P registers driven by the strobes.
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;
    logic [31:0] dp_p = '0;

    always @(posedge clk) begin
        if (bus.loada) dp_a <= bus.dp_data;
        if (bus.loadb) dp_b <= bus.dp_data;
        else if (bus.decb) dp_b <= dp_b - 16'd1;
        if (bus.clrP) dp_p <= '0;
        else if (bus.loadP) dp_p <= dp_p + {16'd0, dp_a};
    end

    assign bus.eqz      = (dp_b == 16'd0);
    assign bus.dp_prod  = dp_p;
    assign wbus.eqz     = 1'b0;
    assign wbus.dp_prod = 8'hA5;

    typedef struct {
        int          idx;
        logic [31:0] prod;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t wq[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("gnt_onehot", 64'($onehot0(bus.gnt)), 64'd1);
            if (bus.rsp_valid != '0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b with no job outstanding", bus.rsp_valid);
                end else begin
                    e = q.pop_front();
                    check("rsp_valid", 64'(bus.rsp_valid), 64'(1) << e.idx);
                    check("rsp_prod",  64'(bus.rsp_prod),  64'(e.prod));
                    check("rsp_err",   64'(bus.rsp_err),   64'(e.err));
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wbus.rsp_valid != '0) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wd_unexpected_rsp: rsp_valid=%b with no job outstanding", wbus.rsp_valid);
            end else begin
                e = wq.pop_front();
                check("wd_rsp_valid", 64'(wbus.rsp_valid), 64'(1) << e.idx);
                check("wd_rsp_prod",  64'(wbus.rsp_prod),  64'(e.prod));
                check("wd_rsp_err",   64'(wbus.rsp_err),   64'(e.err));
            end
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        bus.a_in[i*16 +: 16] = 16'(a);
        bus.b_in[i*16 +: 16] = 16'(b);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
        check({tag, "_gnt"},       64'(bus.gnt), 64'd0);
        check({tag, "_strobes"},   64'({bus.loada, bus.loadb, bus.clrP, bus.loadP, bus.decb}), 64'd0);
        check({tag, "_dp_data"},   64'(bus.dp_data), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_prod"},  64'(bus.rsp_prod), 64'd0);
        check({tag, "_rsp_err"},   64'(bus.rsp_err), 64'd0);
    endtask

    // Waits on negedges for any response; n is the number of negedges waited.
    task automatic wait_rsp(input int bound, output int n, output logic [3:0] who);
        logic seen;
        seen = 1'b0;
        n    = -1;
        who  = '0;
        for (int c = 1; c <= bound && !seen; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin
                seen = 1'b1;
                n    = c;
                who  = bus.rsp_valid;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", bound);
        end
    endtask

    // Single job from IDLE; checks latency, loadP pulse count and a steady grant.
    task automatic run_measured(input int i, input int a, input int b,
                                input int exp_lat, input int exp_pulses);
        int   lat;
        int   pulses;
        logic gnt_ok;
        set_op(i, a, b);
        q.push_back('{i, 32'(a * b), 1'b0});
        bus.req[i] = 1'b1;
        lat    = -1;
        pulses = 0;
        gnt_ok = 1'b1;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.loadP) pulses++;
            if (bus.gnt !== 4'(1 << i)) gnt_ok = 1'b0;
            if (bus.rsp_valid != '0) begin
                lat        = c;
                bus.req[i] = 1'b0;
            end
        end
        check("latency",     64'(lat), 64'(exp_lat));
        check("loadP_count", 64'(pulses), 64'(exp_pulses));
        check("gnt_held",    64'(gnt_ok), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int         n;
        int         lat;
        logic [3:0] who;
        logic       seen;

        rst_n     = 1'b0;
        bus.req   = '0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        wbus.req  = '0;
        wbus.a_in = '0;
        wbus.b_in = '0;
        #12;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: all four pending, b=1; requester 0 re-requests once.
        for (int i = 0; i < 4; i++) set_op(i, 10 + i, 1);
        q.push_back('{0, 32'd10, 1'b0});
        q.push_back('{1, 32'd11, 1'b0});
        q.push_back('{2, 32'd12, 1'b0});
        q.push_back('{3, 32'd13, 1'b0});
        q.push_back('{0, 32'd20, 1'b0});
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_rsp(50, n, who);
            check("contention_gap", 64'(n), (r == 0) ? 64'd5 : 64'd6);
            if (r == 0 && who == 4'b0001) set_op(0, 20, 1);
            else bus.req = bus.req & ~who;
        end
        bus.req = '0;
        @(negedge clk);

        run_measured(0, 3, 4, 8, 4);
        run_measured(2, 7, 0, 4, 0);

        // Request dropped during LOADB still completes.
        set_op(1, 2, 3);
        q.push_back('{1, 32'd6, 1'b0});
        bus.req[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.loadb) seen = 1'b1;
        end
        check("dropped_saw_loadb", 64'(seen), 64'd1);
        bus.req[1] = 1'b0;
        wait_rsp(30, n, who);
        check("dropped_lat", 64'(n), 64'd5);
        @(negedge clk);

        // Reset in the middle of MUL: no response, requester 0 first afterwards.
        set_op(0, 5, 10);
        bus.req = 4'b0001;
        repeat (6) @(negedge clk);
        check("mid_busy",  64'(bus.busy), 64'd1);
        check("mid_loadP", 64'(bus.loadP), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_op(1, 6, 2);
        bus.req = 4'b0011;
        q.push_back('{0, 32'd50, 1'b0});
        q.push_back('{1, 32'd12, 1'b0});
        @(negedge clk);
        check("post_rst_gnt", 64'(bus.gnt), 64'd1);
        wait_rsp(40, n, who);
        check("post_rst_lat0", 64'(n), 64'd13);
        bus.req[0] = 1'b0;
        wait_rsp(40, n, who);
        check("post_rst_lat1", 64'(n), 64'd7);
        bus.req = '0;
        @(negedge clk);

        // Watchdog on the narrow instance: eqz never rises.
        wbus.a_in = 8'h03;
        wbus.b_in = 8'h07;
        wq.push_back('{0, 32'h0000_00A5, 1'b1});
        wbus.req = 2'b01;
        lat = -1;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            if (wbus.rsp_valid != '0) begin
                lat      = c;
                wbus.req = '0;
            end
        end
        check("wd_latency_window", 64'(lat >= 18 && lat <= 19), 64'd1);

        repeat (3) @(negedge clk);
        check("queues_drained", 64'(q.size() + wq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
